// File: rtl/demux1_2_buf_if.sv
// Handshake bundle for demux1_2_buf: one input stream in, two buffered streams out.
// Optional push counters appear when DEMUX1_2_CNT_EN is defined.
interface demux1_2_buf_if #(
    parameter int DATA_W = 4
);
    logic [DATA_W-1:0] demux_in;
    logic              demux_sel;
    logic              demux_in_valid;
    logic              demux_in_ready;
    logic [DATA_W-1:0] demux_out_a;
    logic              demux_out_a_valid;
    logic              demux_out_a_ready;
    logic [DATA_W-1:0] demux_out_b;
    logic              demux_out_b_valid;
    logic              demux_out_b_ready;
`ifdef DEMUX1_2_CNT_EN
    logic [7:0]        demux_cnt_a;
    logic [7:0]        demux_cnt_b;

    modport master (
        output demux_in, demux_sel, demux_in_valid, demux_out_a_ready, demux_out_b_ready,
        input  demux_in_ready, demux_out_a, demux_out_a_valid, demux_out_b, demux_out_b_valid,
        input  demux_cnt_a, demux_cnt_b
    );

    modport slave (
        input  demux_in, demux_sel, demux_in_valid, demux_out_a_ready, demux_out_b_ready,
        output demux_in_ready, demux_out_a, demux_out_a_valid, demux_out_b, demux_out_b_valid,
        output demux_cnt_a, demux_cnt_b
    );
`else
    modport master (
        output demux_in, demux_sel, demux_in_valid, demux_out_a_ready, demux_out_b_ready,
        input  demux_in_ready, demux_out_a, demux_out_a_valid, demux_out_b, demux_out_b_valid
    );

    modport slave (
        input  demux_in, demux_sel, demux_in_valid, demux_out_a_ready, demux_out_b_ready,
        output demux_in_ready, demux_out_a, demux_out_a_valid, demux_out_b, demux_out_b_valid
    );
`endif
endinterface

// File: rtl/demux1_2_buf.sv
// 1:2 demultiplexer steering a nibble stream into two independent FIFOs (A = 0, B = 1).
// Define DEMUX1_2_CNT_EN to add 8-bit wrapping push counters per channel.
module demux1_2_buf #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    demux1_2_buf_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [PTR_W-1:0]  ptr_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    localparam cnt_t FULL_CNT = cnt_t'(DEPTH);

    // Index 0 is channel A, index 1 is channel B throughout.
    word_t mem_q   [2][DEPTH];
    word_t mem_d   [2][DEPTH];
    ptr_t  wr_ptr_q [2];
    ptr_t  wr_ptr_d [2];
    ptr_t  rd_ptr_q [2];
    ptr_t  rd_ptr_d [2];
    cnt_t  count_q  [2];
    cnt_t  count_d  [2];
    logic  ready_en_q;
    logic  ready_en_d;

    logic [1:0] sel_oh;
    logic [1:0] full;
    logic [1:0] not_empty;
    logic [1:0] out_ready;
    logic [1:0] push;
    logic [1:0] pop;
    logic       in_ready;

`ifdef DEMUX1_2_CNT_EN
    logic [7:0] push_cnt_q [2];
    logic [7:0] push_cnt_d [2];
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sel_oh    = {bus.demux_sel, !bus.demux_sel};
        out_ready = {bus.demux_out_b_ready, bus.demux_out_a_ready};
        full      = '0;
        not_empty = '0;
        for (int c = 0; c < 2; c++) begin
            full[c]      = (count_q[c] == FULL_CNT);
            not_empty[c] = (count_q[c] != '0);
        end
        // Ready looks only at the selected FIFO's registered count; a same-cycle pop never helps.
        in_ready = ready_en_q && !full[bus.demux_sel];
        push     = {2{bus.demux_in_valid && in_ready}} & sel_oh;
        pop      = not_empty & out_ready;
    end

    always_comb begin
        ready_en_d = 1'b1;
        mem_d      = mem_q;
        for (int c = 0; c < 2; c++) begin
            wr_ptr_d[c] = wr_ptr_q[c];
            rd_ptr_d[c] = rd_ptr_q[c];
            count_d[c]  = count_q[c] + cnt_t'(push[c]) - cnt_t'(pop[c]);
            if (push[c]) begin
                mem_d[c][wr_ptr_q[c]] = bus.demux_in;
                wr_ptr_d[c]           = wr_ptr_q[c] + ptr_t'(1);
            end
            if (pop[c]) begin
                rd_ptr_d[c] = rd_ptr_q[c] + ptr_t'(1);
            end
        end
    end

`ifdef DEMUX1_2_CNT_EN
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            push_cnt_d[c] = push_cnt_q[c] + 8'(push[c]);
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q <= 1'b0;
            for (int c = 0; c < 2; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                count_q[c]  <= '0;
            end
        end else begin
            ready_en_q <= ready_en_d;
            for (int c = 0; c < 2; c++) begin
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
                count_q[c]  <= count_d[c];
            end
        end
    end

    // NOTE: storage is not reset; an empty count masks stale entries, so outputs still read 0.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef DEMUX1_2_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            push_cnt_q[0] <= '0;
            push_cnt_q[1] <= '0;
        end else begin
            push_cnt_q[0] <= push_cnt_d[0];
            push_cnt_q[1] <= push_cnt_d[1];
        end
    end

    assign bus.demux_cnt_a = push_cnt_q[0];
    assign bus.demux_cnt_b = push_cnt_q[1];
`endif

    assign bus.demux_in_ready    = in_ready;
    assign bus.demux_out_a_valid = not_empty[0];
    assign bus.demux_out_b_valid = not_empty[1];
    assign bus.demux_out_a       = not_empty[0] ? mem_q[0][rd_ptr_q[0]] : '0;
    assign bus.demux_out_b       = not_empty[1] ? mem_q[1][rd_ptr_q[1]] : '0;

endmodule

// File: tb/tb_demux1_2_buf.sv
// Self-checking bench for demux1_2_buf: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations. Honors DEMUX1_2_CNT_EN when defined.
module tb_demux1_2_buf;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    demux1_2_buf_if #(.DATA_W(DATA_W)) bus ();

    demux1_2_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one queue per destination, plus push tallies.
    logic [DATA_W-1:0] qa[$];
    logic [DATA_W-1:0] qb[$];
    bit                ready_en = 0;
    int unsigned       pushes_a = 0;
    int unsigned       pushes_b = 0;

    // Compare process: one time unit before each rising edge, check then advance the model.
    always begin
        logic              exp_ready;
        logic [DATA_W-1:0] exp_a, exp_b;
        int                sel_size;
        @(negedge clk);
        #4;
        if (!rst_n) begin
            qa.delete();
            qb.delete();
            ready_en = 0;
            pushes_a = 0;
            pushes_b = 0;
        end
        exp_a     = (qa.size() != 0) ? qa[0] : '0;
        exp_b     = (qb.size() != 0) ? qb[0] : '0;
        sel_size  = bus.demux_sel ? qb.size() : qa.size();
        exp_ready = ready_en && (sel_size < DEPTH);
        check("m_in_ready", bus.demux_in_ready, exp_ready);
        check("m_a_valid", bus.demux_out_a_valid, qa.size() != 0);
        check("m_b_valid", bus.demux_out_b_valid, qb.size() != 0);
        check("m_out_a", bus.demux_out_a, exp_a);
        check("m_out_b", bus.demux_out_b, exp_b);
`ifdef DEMUX1_2_CNT_EN
        check("m_cnt_a", bus.demux_cnt_a, pushes_a % 256);
        check("m_cnt_b", bus.demux_cnt_b, pushes_b % 256);
`endif
        if (rst_n) begin
            if (qa.size() != 0 && bus.demux_out_a_ready) void'(qa.pop_front());
            if (qb.size() != 0 && bus.demux_out_b_ready) void'(qb.pop_front());
            if (bus.demux_in_valid && exp_ready) begin
                if (bus.demux_sel) begin
                    qb.push_back(bus.demux_in);
                    pushes_b++;
                end else begin
                    qa.push_back(bus.demux_in);
                    pushes_a++;
                end
            end
            ready_en = 1;
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic s, input logic [DATA_W-1:0] d,
                         input logic ra, input logic rb);
        bus.demux_in_valid    = v;
        bus.demux_sel         = s;
        bus.demux_in          = d;
        bus.demux_out_a_ready = ra;
        bus.demux_out_b_ready = rb;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        drive(1'b1, 1'b0, 4'h3, 1'b0, 1'b0);
        #1 rst_n = 1'b0;

        // Reset held with a valid word offered.
        repeat (3) step();
        check("rst_in_ready", bus.demux_in_ready, 1'b0);
        check("rst_a_valid", bus.demux_out_a_valid, 1'b0);
        check("rst_b_valid", bus.demux_out_b_valid, 1'b0);
        check("rst_out_a", bus.demux_out_a, 4'h0);
        check("rst_out_b", bus.demux_out_b, 4'h0);
        drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
        rst_n = 1'b1;
        step();
        check("rel_in_ready", bus.demux_in_ready, 1'b1);

        // Steering: 5 to A, then A to B; each visible for exactly one cycle.
        drive(1'b1, 1'b0, 4'h5, 1'b1, 1'b1);
        step();
        check("st_a_valid", bus.demux_out_a_valid, 1'b1);
        check("st_out_a", bus.demux_out_a, 4'h5);
        drive(1'b1, 1'b1, 4'hA, 1'b1, 1'b1);
        step();
        check("st_a_gone", bus.demux_out_a_valid, 1'b0);
        check("st_b_valid", bus.demux_out_b_valid, 1'b1);
        check("st_out_b", bus.demux_out_b, 4'hA);
        drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
        step();
        check("st_b_gone", bus.demux_out_b_valid, 1'b0);

        // Backpressure on A, B still flows, then full+pop refusal and ordering.
        drive(1'b1, 1'b0, 4'h1, 1'b0, 1'b1);
        step();
        drive(1'b1, 1'b0, 4'h2, 1'b0, 1'b1);
        step();
        drive(1'b1, 1'b0, 4'h3, 1'b0, 1'b1);
        #1 check("bp_full_ready", bus.demux_in_ready, 1'b0);
        step();
        check("bp_head_a", bus.demux_out_a, 4'h1);
        drive(1'b1, 1'b1, 4'hC, 1'b0, 1'b1);
        #1 check("bp_b_ready", bus.demux_in_ready, 1'b1);
        step();
        check("bp_out_b", bus.demux_out_b, 4'hC);
        drive(1'b1, 1'b0, 4'h3, 1'b1, 1'b1);
        #1 check("fp_refused", bus.demux_in_ready, 1'b0);
        step();
        check("fp_out_a2", bus.demux_out_a, 4'h2);
        check("fp_ready_back", bus.demux_in_ready, 1'b1);
        step();
        check("fp_out_a3", bus.demux_out_a, 4'h3);
        drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
        step();
        check("fp_a_empty", bus.demux_out_a_valid, 1'b0);

        // Asynchronous reset with buffered words.
        drive(1'b1, 1'b0, 4'h7, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b0, 4'h8, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b1, 4'h9, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        check("mr_out_a", bus.demux_out_a, 4'h7);
        check("mr_out_b", bus.demux_out_b, 4'h9);
        #1 rst_n = 1'b0;
        #1;
        check("mr_a_drop", bus.demux_out_a_valid, 1'b0);
        check("mr_b_drop", bus.demux_out_b_valid, 1'b0);
        check("mr_in_ready", bus.demux_in_ready, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("mr_a_empty", bus.demux_out_a_valid, 1'b0);
        check("mr_b_empty", bus.demux_out_b_valid, 1'b0);
        check("mr_ready", bus.demux_in_ready, 1'b1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 10) < 7, 1'($urandom), DATA_W'($urandom),
                  1'($urandom), 1'($urandom));
            step();
        end

`ifdef DEMUX1_2_CNT_EN
        // Counter wrap: 257 accepted pushes to B after a fresh reset.
        drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
        #1 rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 257; i++) begin
            drive(1'b1, 1'b1, DATA_W'(i), 1'b1, 1'b1);
            step();
        end
        drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
        check("cnt_b_wrap", bus.demux_cnt_b, 8'd1);
        check("cnt_a_zero", bus.demux_cnt_a, 8'd0);
`endif

        drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
        step();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
